// File: rtl/host_cfg_pkg.sv
// host_cfg_pkg: shared types and constants for the host configuration loader.
//   - opcode_e      : header opcodes
//   - HDR_*         : header field bit positions
//   - trig_entry_t  : trigger-table entry as written to the RAM (129 bits)
//   - PAYLOAD_WORDS : payload words following a WRITE header
// Optional feature macro: HOST_CFG_CHECKSUM_EN adds a fifth (checksum) payload word.
package host_cfg_pkg;

  localparam int CFG_W = 32;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_WRITE  = 4'h1,
    OP_CLEAR  = 4'h2,
    OP_COMMIT = 4'h3
  } opcode_e;

  localparam int HDR_OP_HI  = 31;
  localparam int HDR_OP_LO  = 28;
  localparam int HDR_IDX_HI = 15;
  localparam int HDR_IDX_LO = 0;

  typedef struct packed {
    logic        valid;
    logic [63:0] symbol;
    logic [31:0] price;
    logic [31:0] vol_thresh;
  } trig_entry_t;

`ifdef HOST_CFG_CHECKSUM_EN
  localparam int PAYLOAD_WORDS = 5;
`else
  localparam int PAYLOAD_WORDS = 4;
`endif

endpackage

// File: rtl/host_config_loader_if.sv
// host_config_loader_if: host config word stream plus trigger-table write port.
//   in_config_valid/in_config_data : host -> loader, no backpressure
//   tbl_wr_en/addr/data            : loader -> trigger table RAM
// master = host/table side, slave = loader.
interface host_config_loader_if #(
  parameter int NUM_ENTRIES = 256
);
  import host_cfg_pkg::*;
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic             in_config_valid;
  logic [CFG_W-1:0] in_config_data;
  logic             tbl_wr_en;
  logic [IDX_W-1:0] tbl_wr_addr;
  logic [128:0]     tbl_wr_data;

  modport master (
    output in_config_valid, in_config_data,
    input  tbl_wr_en, tbl_wr_addr, tbl_wr_data
  );

  modport slave (
    input  in_config_valid, in_config_data,
    output tbl_wr_en, tbl_wr_addr, tbl_wr_data
  );
endinterface

// File: rtl/host_cfg_assembler.sv
// host_cfg_assembler: counts payload words and assembles a trigger entry.
//   start   : WRITE header accepted this cycle (clears count, seeds checksum)
//   cap     : payload word valid this cycle
//   word    : config word (header on start, payload on cap)
//   discard : current entry targets an out-of-range index, never written
//   last    : this cap is the final payload word (combinational)
//   done    : registered write strobe, one cycle after the final word
//   entry   : assembled entry, valid while done is high
//   err_csum: sticky checksum mismatch (only with HOST_CFG_CHECKSUM_EN)
module host_cfg_assembler
  import host_cfg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cap,
  input  logic [CFG_W-1:0] word,
  input  logic             discard,
  output logic             last,
  output logic             done,
  output trig_entry_t      entry
`ifdef HOST_CFG_CHECKSUM_EN
  ,
  output logic             err_csum
`endif
);
  localparam int CNT_W = $clog2(PAYLOAD_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_WORDS - 1);
  // Holds every payload word except the one arriving with 'last'.
  localparam int SH_W = (PAYLOAD_WORDS - 1) * CFG_W;

  logic [CNT_W-1:0] cnt_q;
  logic [SH_W-1:0]  sh_q;

  assign last = cap && (cnt_q == LAST_CNT);

`ifdef HOST_CFG_CHECKSUM_EN
  logic [CFG_W-1:0] csum_q;
  logic             csum_ok;
  assign csum_ok = (csum_q == word);

  // Running XOR of header and data words; compared against the final word.
  always_ff @(posedge clk) begin
    if (start)           csum_q <= word;
    else if (cap && !last) csum_q <= csum_q ^ word;
  end
`endif

  always_ff @(posedge clk) begin
    if (cap && !last) sh_q <= {sh_q[SH_W-CFG_W-1:0], word};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      done  <= 1'b0;
      entry <= '0;
`ifdef HOST_CFG_CHECKSUM_EN
      err_csum <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (start) begin
        cnt_q <= '0;
      end else if (cap) begin
        cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
        if (last) begin
`ifdef HOST_CFG_CHECKSUM_EN
          entry <= {1'b1, sh_q};
          done  <= !discard && csum_ok;
          if (!discard && !csum_ok) err_csum <= 1'b1;
`else
          entry <= {1'b1, sh_q, word};
          done  <= !discard;
`endif
        end
      end
    end
  end

endmodule

// File: rtl/host_config_loader.sv
// host_config_loader: parses the host config word stream and writes the
// tick2trade trigger table.
//   clk, reset     : clock, synchronous active-high reset
//   cfg (slave)    : config word in, table write port out
//   cfg_commit     : one-cycle pulse after a COMMIT header
//   cfg_loaded     : sticky, set by COMMIT, cleared by CLEAR
//   busy           : clear sweep in progress
//   err_opcode     : sticky, unknown opcode seen
//   err_index      : sticky, WRITE index >= NUM_ENTRIES
//   err_dropped    : sticky, word arrived during the clear sweep
//   err_checksum   : sticky, checksum mismatch (HOST_CFG_CHECKSUM_EN only)
// Optional feature macro: HOST_CFG_CHECKSUM_EN.
module host_config_loader
  import host_cfg_pkg::*;
#(
  parameter int NUM_ENTRIES = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  host_config_loader_if.slave  cfg,
  output logic                 cfg_commit,
  output logic                 cfg_loaded,
  output logic                 busy,
  output logic                 err_opcode,
  output logic                 err_index,
  output logic                 err_dropped
`ifdef HOST_CFG_CHECKSUM_EN
  ,
  output logic                 err_checksum
`endif
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CLEAR} state_e;

  state_e           state_q, state_d;
  logic [3:0]       op;
  logic [15:0]      idx_f;
  logic             idx_ok;
  logic [IDX_W-1:0] idx_q, clr_addr_q;
  logic             discard_q, clr_last;
  logic             do_start, do_clear, do_commit, do_illegal;
  logic             asm_last, asm_done;
  trig_entry_t      asm_entry;

  assign op       = cfg.in_config_data[HDR_OP_HI:HDR_OP_LO];
  assign idx_f    = cfg.in_config_data[HDR_IDX_HI:HDR_IDX_LO];
  assign idx_ok   = idx_f < 16'(NUM_ENTRIES);
  assign clr_last = clr_addr_q == IDX_W'(NUM_ENTRIES - 1);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    do_start   = 1'b0;
    do_clear   = 1'b0;
    do_commit  = 1'b0;
    do_illegal = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cfg.in_config_valid) begin
          case (op)
            OP_NOP:    ;
            OP_WRITE:  begin do_start = 1'b1; state_d = S_PAYLOAD; end
            OP_CLEAR:  begin do_clear = 1'b1; state_d = S_CLEAR;   end
            OP_COMMIT: do_commit = 1'b1;
            default:   do_illegal = 1'b1;
          endcase
        end
      end
      // Leaving on the final word lets the next header land with no bubble.
      S_PAYLOAD: if (asm_last) state_d = S_IDLE;
      // Exit on the last address so the sweep never starts a second pass.
      S_CLEAR:   if (clr_last) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q       <= '0;
      discard_q   <= 1'b0;
      clr_addr_q  <= '0;
      cfg_commit  <= 1'b0;
      cfg_loaded  <= 1'b0;
      err_opcode  <= 1'b0;
      err_index   <= 1'b0;
      err_dropped <= 1'b0;
    end else begin
      cfg_commit <= do_commit;
      if (do_start) begin
        idx_q     <= idx_f[IDX_W-1:0];
        discard_q <= !idx_ok;
        if (!idx_ok) err_index <= 1'b1;
      end
      if (do_commit) cfg_loaded <= 1'b1;
      if (do_clear) begin
        cfg_loaded <= 1'b0;
        clr_addr_q <= '0;
      end else if (state_q == S_CLEAR) begin
        clr_addr_q <= clr_addr_q + IDX_W'(1);
      end
      if (do_illegal) err_opcode <= 1'b1;
      if (state_q == S_CLEAR && cfg.in_config_valid) err_dropped <= 1'b1;
    end
  end

  host_cfg_assembler u_asm (
    .clk      (clk),
    .reset    (reset),
    .start    (do_start),
    .cap      (state_q == S_PAYLOAD && cfg.in_config_valid),
    .word     (cfg.in_config_data),
    .discard  (discard_q),
    .last     (asm_last),
    .done     (asm_done),
    .entry    (asm_entry)
`ifdef HOST_CFG_CHECKSUM_EN
    ,
    .err_csum (err_checksum)
`endif
  );

  // Sweep and entry writes never overlap: a CLEAR header can only be taken
  // in or after the cycle that carries the entry write.
  assign busy            = (state_q == S_CLEAR);
  assign cfg.tbl_wr_en   = busy || asm_done;
  assign cfg.tbl_wr_addr = busy ? clr_addr_q : idx_q;
  assign cfg.tbl_wr_data = asm_done ? asm_entry : '0;

endmodule

// File: tb/tb_host_config_loader.sv
module tb_host_config_loader;
  import host_cfg_pkg::*;

  localparam int N  = 256;
  localparam int AW = $clog2(N);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  host_config_loader_if #(.NUM_ENTRIES(N)) bus ();
  logic cfg_commit, cfg_loaded, busy, err_opcode, err_index, err_dropped;
`ifdef HOST_CFG_CHECKSUM_EN
  logic err_checksum;
`endif

  host_config_loader #(.NUM_ENTRIES(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg         (bus),
    .cfg_commit  (cfg_commit),
    .cfg_loaded  (cfg_loaded),
    .busy        (busy),
    .err_opcode  (err_opcode),
    .err_index   (err_index),
    .err_dropped (err_dropped)
`ifdef HOST_CFG_CHECKSUM_EN
    ,
    .err_checksum(err_checksum)
`endif
  );

  int vecs = 0;
  int errs = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [128:0]  data;
  } wr_t;
  wr_t obs_q[$];
  int  busy_cyc   = 0;
  int  commit_cnt = 0;

  // Passive monitor of table writes and status pulses.
  always @(negedge clk) begin
    if (bus.tbl_wr_en === 1'b1) obs_q.push_back('{addr: bus.tbl_wr_addr, data: bus.tbl_wr_data});
    if (busy === 1'b1) busy_cyc++;
    if (cfg_commit === 1'b1) commit_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mkhdr(input logic [3:0] op, input logic [15:0] idx);
    logic [11:0] r;
    r = 12'($urandom);
    return {op, r, idx};
  endfunction

  task automatic put(input logic [31:0] w);
    bus.in_config_valid = 1'b1;
    bus.in_config_data  = w;
    @(posedge clk); #1;
    bus.in_config_valid = 1'b0;
    bus.in_config_data  = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_config_valid = 1'b0;
    bus.in_config_data  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    obs_q.delete();
  endtask

  task automatic rand_words(output logic [31:0] w [4]);
    for (int i = 0; i < 4; i++) w[i] = $urandom;
  endtask

  task automatic wait_not_busy(input string tag);
    int t = 0;
    while (busy === 1'b1 && t < 2 * N) begin @(negedge clk); t++; end
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL %s busy timeout: busy=%b after %0d cycles, required 0", tag, busy, t);
    end
  endtask

  // Sends one WRITE command and checks the table write one cycle after the
  // final payload word, against the entry the spec defines for these words.
  task automatic do_write(input logic [15:0] idx, input logic [31:0] w [4], input int maxgap,
                          input bit fixed, input bit corrupt, input string tag);
    logic [31:0]  h;
    logic [31:0]  cs;
    logic [128:0] exp_d;
    bit           exp_wr;
    exp_wr = (idx < N) && !corrupt;
    exp_d  = {1'b1, w[0], w[1], w[2], w[3]};
    h  = mkhdr(OP_WRITE, idx);
    cs = h;
    put(h);
    for (int i = 0; i < 4; i++) begin
      idle(fixed ? maxgap : int'($urandom_range(0, maxgap)));
      put(w[i]);
      cs = cs ^ w[i];
    end
`ifdef HOST_CFG_CHECKSUM_EN
    idle(fixed ? maxgap : int'($urandom_range(0, maxgap)));
    put(corrupt ? ~cs : cs);
`endif
    @(negedge clk);
    vecs++;
    if (bus.tbl_wr_en !== exp_wr) begin
      errs++;
      $display("FAIL %s wr_en idx=%0d: got %b, required %b", tag, idx, bus.tbl_wr_en, exp_wr);
    end
    if (exp_wr) begin
      vecs++;
      if (bus.tbl_wr_addr !== idx[AW-1:0] || bus.tbl_wr_data !== exp_d) begin
        errs++;
        $display("FAIL %s addr/data: got %0d/%h, required %0d/%h", tag,
                 bus.tbl_wr_addr, bus.tbl_wr_data, idx, exp_d);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vecs++;
    if ({bus.tbl_wr_en, cfg_commit, cfg_loaded, busy, err_opcode, err_index, err_dropped} !== 7'b0) begin
      errs++;
      $display("FAIL reset status: got %b, required 0",
               {bus.tbl_wr_en, cfg_commit, cfg_loaded, busy, err_opcode, err_index, err_dropped});
    end
    vecs++;
    if (bus.tbl_wr_data !== 129'b0 || bus.tbl_wr_addr !== '0) begin
      errs++;
      $display("FAIL reset bus: got addr %0d data %h, required 0", bus.tbl_wr_addr, bus.tbl_wr_data);
    end
`ifdef HOST_CFG_CHECKSUM_EN
    vecs++;
    if (err_checksum !== 1'b0) begin
      errs++;
      $display("FAIL reset err_checksum: got %b, required 0", err_checksum);
    end
`endif
  endtask

  task automatic test_write_basic();
    logic [31:0] w [4];
    w = '{32'h41424344, 32'h45460000, 32'd1000, 32'd500};
    do_reset();
    do_write(16'd5, w, 0, 1'b1, 1'b0, "basic");
    idle(3);
    vecs++;
    if (obs_q.size() != 1 || obs_q[0].data !== {1'b1, 64'h4142434445460000, 32'd1000, 32'd500}) begin
      errs++;
      $display("FAIL basic count/data: got %0d writes, required 1 with literal entry", obs_q.size());
    end
  endtask

  task automatic test_gaps();
    logic [31:0] w [4];
    do_reset();
    rand_words(w);
    do_write(16'd7, w, 3, 1'b1, 1'b0, "gaps");
    idle(4);
    vecs++;
    if (obs_q.size() != 1 || {err_opcode, err_index, err_dropped} !== 3'b0) begin
      errs++;
      $display("FAIL gaps: got %0d writes errs %b, required 1 write errs 000",
               obs_q.size(), {err_opcode, err_index, err_dropped});
    end
  endtask

  task automatic test_bad_index();
    logic [31:0] w [4];
    do_reset();
    rand_words(w);
    do_write(16'(N), w, 0, 1'b1, 1'b0, "badidx");
    rand_words(w);
    do_write(16'd1, w, 0, 1'b1, 1'b0, "afterbad");
    idle(2);
    vecs++;
    if (err_index !== 1'b1 || obs_q.size() != 1 || obs_q[0].addr !== AW'(1)) begin
      errs++;
      $display("FAIL badidx: got err_index %b, %0d writes, required 1 and 1 write to addr 1",
               err_index, obs_q.size());
    end
  endtask

  task automatic test_clear();
    int b0;
    int bad = 0;
    do_reset();
    b0 = busy_cyc;
    put(mkhdr(OP_CLEAR, 16'($urandom)));
    @(negedge clk);
    vecs++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL clear busy start: got %b, required 1", busy);
    end
    idle(40);
    put($urandom);
    idle(60);
    put(mkhdr(OP_WRITE, 16'd2));
    wait_not_busy("clear");
    idle(3);
    for (int i = 0; i < obs_q.size(); i++)
      if (obs_q[i].addr !== AW'(i) || obs_q[i].data !== 129'b0) bad++;
    vecs++;
    if (obs_q.size() != N || bad != 0) begin
      errs++;
      $display("FAIL clear sweep: got %0d writes (%0d wrong), required %0d zero writes in order",
               obs_q.size(), bad, N);
    end
    vecs++;
    if (busy_cyc - b0 != N) begin
      errs++;
      $display("FAIL clear busy length: got %0d, required %0d", busy_cyc - b0, N);
    end
    vecs++;
    if ({err_dropped, err_opcode, err_index} !== 3'b100) begin
      errs++;
      $display("FAIL clear flags: got drop/op/idx %b, required 100", {err_dropped, err_opcode, err_index});
    end
  endtask

  task automatic test_commit();
    logic [31:0] w [4];
    int c0;
    do_reset();
    c0 = commit_cnt;
    rand_words(w);
    do_write(16'd3, w, 1, 1'b0, 1'b0, "commit_wr");
    put(mkhdr(OP_COMMIT, 16'($urandom)));
    @(negedge clk);
    vecs++;
    if ({cfg_commit, cfg_loaded} !== 2'b11) begin
      errs++;
      $display("FAIL commit pulse: got commit/loaded %b, required 11", {cfg_commit, cfg_loaded});
    end
    put(mkhdr(4'hF, 16'($urandom)));
    put(mkhdr(OP_NOP, 16'($urandom)));
    @(negedge clk);
    vecs++;
    if ({cfg_commit, cfg_loaded, err_opcode} !== 3'b011 || commit_cnt - c0 != 1) begin
      errs++;
      $display("FAIL commit after: got commit/loaded/errop %b pulses %0d, required 011 and 1",
               {cfg_commit, cfg_loaded, err_opcode}, commit_cnt - c0);
    end
    put(mkhdr(OP_CLEAR, 16'd0));
    @(negedge clk);
    vecs++;
    if (cfg_loaded !== 1'b0) begin
      errs++;
      $display("FAIL clear drops loaded: got %b, required 0", cfg_loaded);
    end
    wait_not_busy("commit_clear");
  endtask

  task automatic test_reset_abort();
    logic [31:0] w [4];
    do_reset();
    rand_words(w);
    do_write(16'd300, w, 0, 1'b1, 1'b0, "abort_pre");
    put(mkhdr(OP_WRITE, 16'd11));
    put(w[0]);
    put(w[1]);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vecs++;
    if ({bus.tbl_wr_en, err_index} !== 2'b00) begin
      errs++;
      $display("FAIL abort reset: got wr_en/err_index %b, required 00", {bus.tbl_wr_en, err_index});
    end
    obs_q.delete();
    rand_words(w);
    do_write(16'd9, w, 0, 1'b1, 1'b0, "abort_post");
    idle(6);
    vecs++;
    if (obs_q.size() != 1 || obs_q[0].addr !== AW'(9)) begin
      errs++;
      $display("FAIL abort writes: got %0d writes, required only addr 9", obs_q.size());
    end
  endtask

`ifdef HOST_CFG_CHECKSUM_EN
  task automatic test_checksum();
    logic [31:0] w [4];
    do_reset();
    rand_words(w);
    do_write(16'd20, w, 1, 1'b0, 1'b1, "csum_bad");
    vecs++;
    if (err_checksum !== 1'b1) begin
      errs++;
      $display("FAIL csum flag: got %b, required 1", err_checksum);
    end
    rand_words(w);
    do_write(16'd21, w, 1, 1'b0, 1'b0, "csum_good");
  endtask
`endif

  // Random command mix issued back to back; reference keeps expected write
  // count and sticky flags from the command semantics alone.
  task automatic test_back_to_back();
    logic [31:0] w [4];
    int n_exp = 0;
    bit e_op = 0, e_idx = 0, e_cs = 0;
    int r;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      rand_words(w);
      if (r <= 5) begin
        do_write(16'($urandom_range(0, N - 1)), w, 2, 1'b0, 1'b0, "rand_wr");
        n_exp++;
      end else if (r == 6) begin
        do_write(16'($urandom_range(N, 65535)), w, 2, 1'b0, 1'b0, "rand_oob");
        e_idx = 1;
      end else if (r == 7) begin
        put(mkhdr(OP_NOP, 16'($urandom)));
      end else if (r == 8) begin
        put(mkhdr(4'($urandom_range(4, 15)), 16'($urandom)));
        e_op = 1;
      end else begin
`ifdef HOST_CFG_CHECKSUM_EN
        do_write(16'($urandom_range(0, N - 1)), w, 0, 1'b0, 1'b1, "rand_csum");
        e_cs = 1;
`else
        do_write(16'($urandom_range(0, N - 1)), w, 0, 1'b0, 1'b0, "rand_wr0");
        n_exp++;
`endif
      end
    end
    idle(3);
    vecs++;
    if (obs_q.size() != n_exp) begin
      errs++;
      $display("FAIL rand write count: got %0d, required %0d", obs_q.size(), n_exp);
    end
    vecs++;
    if ({err_opcode, err_index, err_dropped} !== {e_op, e_idx, 1'b0}) begin
      errs++;
      $display("FAIL rand flags: got %b, required %b", {err_opcode, err_index, err_dropped}, {e_op, e_idx, 1'b0});
    end
`ifdef HOST_CFG_CHECKSUM_EN
    vecs++;
    if (err_checksum !== e_cs) begin
      errs++;
      $display("FAIL rand err_checksum: got %b, required %b", err_checksum, e_cs);
    end
`else
    if (e_cs) $display("note: checksum path not built");
`endif
  endtask

  initial begin
    bus.in_config_valid = 1'b0;
    bus.in_config_data  = '0;
    test_reset();
    test_write_basic();
    test_gaps();
    test_bad_index();
    test_clear();
    test_commit();
    test_reset_abort();
`ifdef HOST_CFG_CHECKSUM_EN
    test_checksum();
`endif
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/host_config_loader.md
Name: host_config_loader

Overview:
- Consumes the host configuration word stream (in_config_valid / in_config_data) driven by the host agent or real host.
- Parses command headers and assembles multi-word trigger-table entries (symbol, price, volume threshold).
- Issues single-cycle writes into the tick2trade trigger table. Sits directly downstream of the host interface and upstream of the trigger table RAM.
- No backpressure exists on the host side. Every valid word is consumed or accounted for as dropped.

Parameters:
NUM_ENTRIES, 256, trigger table depth; power of two, 2..4096
IDX_W, $clog2(NUM_ENTRIES), table address width (derived localparam)
CFG_W, 32, config word width; fixed at 32, other values unsupported

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_config_valid  in  1  config word valid this cycle
in_config_data  in  CFG_W  config word
tbl_wr_en  out  1  table write strobe, one cycle
tbl_wr_addr  out  IDX_W  table write index
tbl_wr_data  out  129  {valid, symbol[63:0], price[31:0], vol_thresh[31:0]}
cfg_commit  out  1  one-cycle pulse on COMMIT command
cfg_loaded  out  1  sticky; set by COMMIT, cleared by CLEAR or reset
busy  out  1  high while clear sweep active
err_opcode  out  1  sticky; unknown opcode seen
err_index  out  1  sticky; index >= NUM_ENTRIES
err_dropped  out  1  sticky; word arrived during clear sweep

Behaviour:
- Header word format: [31:28] opcode, [27:16] reserved (ignored), [15:0] index.
- Opcodes: 0x1 WRITE, 0x2 CLEAR, 0x3 COMMIT, 0x0 NOP. All others are illegal.
- Reset: all outputs 0; FSM to IDLE; payload counter 0.
- FSM states: IDLE, PAYLOAD, CLEAR.
- IDLE, valid word = header:
  - WRITE with index < NUM_ENTRIES: latch index, go to PAYLOAD, word count 0.
  - WRITE with index out of range: set err_index, go to PAYLOAD in discard mode. Consume 4 words, no write.
  - CLEAR: go to CLEAR, sweep address 0; busy=1 in the following cycle.
  - COMMIT: cfg_commit=1 next cycle, cfg_loaded=1.
  - NOP: ignored.
  - Illegal opcode: set err_opcode, stay in IDLE; the word is discarded.
- PAYLOAD:
  - Words 0..3 = symbol_hi, symbol_lo, price, vol_thresh. Capture only on valid; gaps of any length are allowed.
  - On capture of word 3: tbl_wr_en=1 in the next cycle with the latched addr, data valid bit=1. Return to IDLE.
  - Latency: last payload word to tbl_wr_en is 1 cycle, registered output.
- CLEAR:
  - Writes data=0 to addresses 0..NUM_ENTRIES-1, one per cycle; tbl_wr_en high for exactly NUM_ENTRIES consecutive cycles.
  - cfg_loaded cleared on entry.
  - Valid words during CLEAR are dropped and set err_dropped.
  - After the last address, busy drops the next cycle and the FSM returns to IDLE. The address counter must not wrap into a second pass.
- A header arriving in the cycle right after a WRITE completes is accepted normally, so back-to-back commands work with no bubble.
- Reset mid-operation (PAYLOAD or CLEAR): abort immediately. No further writes, partial entry discarded, errors cleared.
- Sticky error flags are cleared only by reset.

Optional Feature:
- Macro: HOST_CFG_CHECKSUM_EN.
- When defined, WRITE carries a 5th payload word: XOR of the header and the 4 payload words.
  - Match: write is issued 1 cycle after word 4.
  - Mismatch: no write, err_checksum (extra sticky output port) set.
- When undefined, 4 payload words, no err_checksum port, no checksum logic.

Decomposition:
- Package host_cfg_pkg holds:
  - opcode enum (OP_NOP, OP_WRITE, OP_CLEAR, OP_COMMIT)
  - header field bit positions
  - trig_entry_t packed struct (valid, symbol, price, vol_thresh)
  - PAYLOAD_WORDS constant (4, or 5 under the macro)
- Sub-module host_cfg_assembler: payload counter plus entry shift/capture register, with done pulse and discard input. The FSM and clear sweep stay in the top.

Test Plan:
- Reset, then WRITE idx 5 + {0x41424344, 0x45460000, 1000, 500} → one tbl_wr_en, addr 5, data {1, 0x4142434445460000, 1000, 500}, 1 cycle after the last word.
- WRITE idx 7 with 3 idle cycles between each payload word → single write to addr 7, correct data, no errors.
- WRITE idx NUM_ENTRIES (256) + 4 words, then WRITE idx 1 → err_index=1, no write for idx 256, idx 1 written correctly.
- CLEAR with 2 config words injected mid-sweep → exactly 256 writes of 0 to addrs 0..255 in order, err_dropped=1, busy high 256 cycles.
- WRITE idx 3, COMMIT, opcode 0xF → cfg_commit pulses once, cfg_loaded=1, err_opcode=1. A subsequent CLEAR drops cfg_loaded.
- Reset asserted after 2 of 4 payload words, then a fresh WRITE idx 9 → no write to the aborted index, idx 9 written. Under HOST_CFG_CHECKSUM_EN, a corrupted checksum word → no write, err_checksum=1.
